// File: rtl/keyboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keyboard_pkg
//  Purpose  : Shared constants, types and helpers for the 4x4 keypad scanner.
//             It defines the keypad geometry, the four one-cold row-drive
//             patterns and the row/column-to-key index mapping.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package keyboard_pkg;

  localparam int unsigned ROWS  = 4;
  localparam int unsigned COLS  = 4;
  localparam int unsigned KEY_W = ROWS * COLS;

  // Row index doubles as the scan state.
  typedef logic [1:0] row_idx_t;

  localparam logic [1:0] S_ROW0 = 2'd0;
  localparam logic [1:0] S_ROW1 = 2'd1;
  localparam logic [1:0] S_ROW2 = 2'd2;
  localparam logic [1:0] S_ROW3 = 2'd3;

  // One-cold row drive: the driven row is pulled low.
  localparam logic [3:0] ROW0 = 4'b1110;
  localparam logic [3:0] ROW1 = 4'b1101;
  localparam logic [3:0] ROW2 = 4'b1011;
  localparam logic [3:0] ROW3 = 4'b0111;

  // Flat key index for a row/column pair.
  function automatic int unsigned idx(input int unsigned r, input int unsigned c);
    return r * COLS + c;
  endfunction

  function automatic logic [3:0] row_drive(input row_idx_t r);
    logic [3:0] drv;
    drv = ROW0;
    case (r)
      S_ROW0:  drv = ROW0;
      S_ROW1:  drv = ROW1;
      S_ROW2:  drv = ROW2;
      S_ROW3:  drv = ROW3;
      default: drv = ROW0;
    endcase
    return drv;
  endfunction

endpackage : keyboard_pkg
`default_nettype wire

// File: rtl/keyboard_scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : scan_tick_gen
//  Purpose  : Row-dwell divider. It counts 0..NUM_FOR_200HZ-1, wraps to 0, and
//             raises tick for the single clock in which the count is at
//             its terminal value.
//  Ports    : clk   - system clock
//             rst_n - asynchronous active-low reset
//             tick  - one-clock pulse at the end of each row dwell
//  Revision : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
  parameter int unsigned NUM_FOR_200HZ = 250000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned       CNT_W   = (NUM_FOR_200HZ > 1) ? $clog2(NUM_FOR_200HZ) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(NUM_FOR_200HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : scan_tick_gen
`default_nettype wire

// File: rtl/keyboard.sv
`default_nettype none
// ============================================================================
//  Module   : keyboard
//  Purpose  : 4x4 matrix keypad scanner. It drives one row low per dwell period
//             and latches that row's active-low columns at the end of the
//             dwell. It keeps a held-key map and pulses once per new press.
//             The slow scan rate is also the contact debounce.
//  Ports    : clk       - system clock
//             rst_n     - asynchronous active-low reset
//             col[3:0]  - keypad columns, active low, asynchronous to clk
//             row[3:0]  - registered one-cold row drive
//             key_out   - held-key map, bit = row_idx*4 + col_idx
//             key_pulse - one-clock pulse per key on each 0->1 of key_out
//  Revision : 1.0 - initial release
// ============================================================================
module keyboard
  import keyboard_pkg::*;
#(
  parameter int unsigned NUM_FOR_200HZ = 250000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [COLS-1:0]  col,
  output logic [ROWS-1:0]  row,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W-1:0] key_pulse
);

  logic tick;

  logic [COLS-1:0]  col_meta_q, col_meta_d;
  logic [COLS-1:0]  col_s_q,    col_s_d;
  row_idx_t         row_idx_q,  row_idx_d;
  logic [ROWS-1:0]  row_q,      row_d;
  logic [KEY_W-1:0] key_out_q,  key_out_d;
  // key_out delayed by one clock, used for rising-edge detection.
  logic [KEY_W-1:0] key_prev_q, key_prev_d;
  logic [KEY_W-1:0] key_pulse_q, key_pulse_d;

  scan_tick_gen #(
    .NUM_FOR_200HZ (NUM_FOR_200HZ)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    // The columns are asynchronous, so they pass through two flops before use.
    col_meta_d = col;
    col_s_d    = col_meta_q;

    row_idx_d  = row_idx_q;
    row_d      = row_q;
    key_out_d  = key_out_q;

    if (tick) begin
      // Latch the row that is driven now. Then move the drive to the next row
      // on the same edge, so each row gets exactly one full dwell.
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (row_idx_q == row_idx_t'(r)) begin
          key_out_d[idx(r, 0) +: COLS] = ~col_s_q;
        end
      end
      row_idx_d = row_idx_q + 2'd1;
      row_d     = row_drive(row_idx_q + 2'd1);
    end

    key_prev_d  = key_out_q;
    key_pulse_d = key_out_q & ~key_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q  <= '1;
      col_s_q     <= '1;
      row_idx_q   <= S_ROW0;
      row_q       <= ROW0;
      key_out_q   <= '0;
      key_prev_q  <= '0;
      key_pulse_q <= '0;
    end else begin
      col_meta_q  <= col_meta_d;
      col_s_q     <= col_s_d;
      row_idx_q   <= row_idx_d;
      row_q       <= row_d;
      key_out_q   <= key_out_d;
      key_prev_q  <= key_prev_d;
      key_pulse_q <= key_pulse_d;
    end
  end

  assign row       = row_q;
  assign key_out   = key_out_q;
  assign key_pulse = key_pulse_q;

endmodule : keyboard
`default_nettype wire

// File: tb/tb_keyboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keyboard
//  Purpose  : Self-checking bench for the keypad scanner. A reference model
//             works out the row, the key map and the expected press pulses
//             from elapsed cycles since reset. Expected pulses go into a
//             scoreboard queue, and a monitor compares them with the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keyboard;

  localparam int N = 20;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col   = 4'hF;
  logic [3:0]  row;
  logic [15:0] key_out;
  logic [15:0] key_pulse;

  keyboard #(
    .NUM_FOR_200HZ (N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col       (col),
    .row       (row),
    .key_out   (key_out),
    .key_pulse (key_pulse)
  );

  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] mask;
    longint      cyc;
  } exp_t;

  exp_t        sb[$];
  longint      gcyc   = 0;       // clock edges seen while out of reset
  int          k      = 0;       // edges since the last reset release
  logic [3:0]  h1     = 4'hF;    // col sampled one edge ago
  logic [3:0]  h2     = 4'hF;    // col sampled two edges ago
  logic [15:0] m_key  = '0;      // model key map
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  // Reference model: the row changes every N edges. At the end of each dwell
  // the model stores the column value seen two edges earlier into that row.
  // A newly set bit gives a pulse one clock later.
  always @(posedge clk or negedge rst_n) begin
    logic [15:0] nk;
    int          r;
    if (!rst_n) begin
      k     = 0;
      h1    = 4'hF;
      h2    = 4'hF;
      m_key = '0;
      sb.delete();
    end else begin
      gcyc++;
      k++;
      if (k % N == 0) begin
        r  = ((k - 1) / N) % 4;
        nk = m_key;
        for (int c = 0; c < 4; c++) nk[r*4 + c] = ~h2[c];
        if ((nk & ~m_key) != 16'h0) sb.push_back('{nk & ~m_key, gcyc + 1});
        m_key = nk;
      end
      h2 = h1;
      h1 = col;
    end
  end

  // Monitor: compare row and map every cycle, and score pulses as they appear.
  always @(negedge clk) begin
    int         ri;
    logic [3:0] er;
    exp_t       e;
    if (mon_en) begin
      ri = (k / N) % 4;
      er = 4'hF ^ (4'h1 << ri);
      chk("row", {12'h0, row}, {12'h0, er});
      chk("key_out", key_out, m_key);
      if (sb.size() > 0 && sb[0].cyc < gcyc) begin
        e = sb.pop_front();
        chk("missed_pulse", 16'h0, e.mask);
      end
      if (key_pulse != 16'h0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", key_pulse, 16'h0);
        end else begin
          e = sb.pop_front();
          chk("pulse_mask", key_pulse, e.mask);
          chk("pulse_cycle", 16'(gcyc), 16'(e.cyc));
        end
      end
    end
  end

  task automatic hold_col(input logic [3:0] v, input int cycles);
    @(negedge clk);
    col = v;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    logic [3:0] v;
    int         len;
    bit         found;

    rst_n = 1'b0;
    col   = 4'hF;
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (9) @(negedge clk);
    chk("reset_row", {12'h0, row}, 16'h000E);
    chk("reset_key_out", key_out, 16'h0);
    chk("reset_pulse", key_pulse, 16'h0);
    rst_n = 1'b1;

    // Idle scan, then a press on column 3, then release.
    hold_col(4'hF, 90);
    hold_col(4'h7, 90);
    hold_col(4'hF, 90);
    // Column 0 held for five full scans must pulse only once per row.
    hold_col(4'hE, 5 * 4 * N);

    // Reset in the middle of the row-2 dwell while the key is still held.
    found = 1'b0;
    for (int i = 0; i < 8 * N; i++) begin
      if ((k / N) % 4 == 2 && k % N == N / 2) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("find_row2_dwell", {15'h0, found}, 16'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("midscan_reset_row", {12'h0, row}, 16'h000E);
    chk("midscan_reset_key_out", key_out, 16'h0);
    chk("midscan_reset_pulse", key_pulse, 16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6 * N) @(negedge clk);

    // Random column patterns with random hold times.
    for (int s = 0; s < 40; s++) begin
      v   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) v = 4'hF;
      len = $urandom_range(1, 70);
      hold_col(v, len);
    end

    hold_col(4'hF, 5 * N);
    chk("scoreboard_empty", 16'(sb.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_keyboard
`default_nettype wire
